// File: rtl/wi_dispatch.sv
// Work-item dispatcher: pops descriptors in order from a fall-through queue and routes them to
// the pf or simd core, bounding outstanding items per core and tracking workload completion.
module wi_dispatch #(
   parameter int unsigned WI_WIDTH    = 64,
   parameter int unsigned WL_LEN_BITS = 32,
   parameter int unsigned MAX_OUT     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [WL_LEN_BITS-1:0] wl_len,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   input  logic                   q_empty,
   output logic                   q_pop,
   input  logic [WI_WIDTH-1:0]    q_data,
   output logic                   pf_valid,
   output logic [WI_WIDTH-1:0]    pf_data,
   input  logic                   pf_ready,
   input  logic                   pf_cmpl,
   output logic                   simd_valid,
   output logic [WI_WIDTH-1:0]    simd_data,
   input  logic                   simd_ready,
   input  logic                   simd_cmpl
);

   localparam int unsigned CntW = 4;
   localparam logic [CntW-1:0] MaxOut = CntW'(MAX_OUT);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e                 state_q, state_d;
   logic [WL_LEN_BITS-1:0] len_q, len_d;
   logic [WL_LEN_BITS-1:0] issued_q, issued_d;
   logic [WL_LEN_BITS-1:0] completed_q, completed_d;
   logic [CntW-1:0]        pf_cnt_q, pf_cnt_d;
   logic [CntW-1:0]        simd_cnt_q, simd_cnt_d;
   logic                   pf_valid_q, pf_valid_d;
   logic                   simd_valid_q, simd_valid_d;
   logic [WI_WIDTH-1:0]    pf_data_q, pf_data_d;
   logic [WI_WIDTH-1:0]    simd_data_q, simd_data_d;
   logic                   err_q, err_d;

   logic tgt_simd;
   logic pf_free, simd_free;
   logic pop_ok, pop_pf, pop_simd;
   logic pf_cmpl_ok, simd_cmpl_ok;

   // Pop decision: the head item blocks the queue when its own core cannot take it.
   always_comb begin
      tgt_simd     = q_data[WI_WIDTH-1];
      pf_free      = !pf_valid_q || pf_ready;
      simd_free    = !simd_valid_q || simd_ready;
      pop_ok       = 1'b0;
      if (state_q == StRun && !q_empty && issued_q < len_q) begin
         if (tgt_simd) begin
            pop_ok = (simd_cnt_q < MaxOut) && simd_free;
         end else begin
            pop_ok = (pf_cnt_q < MaxOut) && pf_free;
         end
      end
      pop_pf       = pop_ok && !tgt_simd;
      pop_simd     = pop_ok && tgt_simd;
      pf_cmpl_ok   = pf_cmpl && (pf_cnt_q != '0);
      simd_cmpl_ok = simd_cmpl && (simd_cnt_q != '0);
   end

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      issued_d     = issued_q + WL_LEN_BITS'(pop_ok);
      completed_d  = completed_q + WL_LEN_BITS'(pf_cmpl_ok) + WL_LEN_BITS'(simd_cmpl_ok);
      pf_cnt_d     = pf_cnt_q + CntW'(pop_pf) - CntW'(pf_cmpl_ok);
      simd_cnt_d   = simd_cnt_q + CntW'(pop_simd) - CntW'(simd_cmpl_ok);
      pf_valid_d   = pf_valid_q;
      simd_valid_d = simd_valid_q;
      pf_data_d    = pf_data_q;
      simd_data_d  = simd_data_q;
      err_d        = err_q | (pf_cmpl && !pf_cmpl_ok) | (simd_cmpl && !simd_cmpl_ok);

      if (pop_pf) begin
         pf_valid_d = 1'b1;
         pf_data_d  = q_data;
      end else if (pf_ready) begin
         pf_valid_d = 1'b0;
      end

      if (pop_simd) begin
         simd_valid_d = 1'b1;
         simd_data_d  = q_data;
      end else if (simd_ready) begin
         simd_valid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               len_d       = wl_len;
               issued_d    = '0;
               completed_d = '0;
               state_d     = (wl_len != '0) ? StRun : StDone;
            end
         end
         StRun: begin
            if (issued_q == len_q) state_d = StDrain;
         end
         StDrain: begin
            if (completed_q == len_q) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         len_q        <= '0;
         issued_q     <= '0;
         completed_q  <= '0;
         pf_cnt_q     <= '0;
         simd_cnt_q   <= '0;
         pf_valid_q   <= 1'b0;
         simd_valid_q <= 1'b0;
         pf_data_q    <= '0;
         simd_data_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         issued_q     <= issued_d;
         completed_q  <= completed_d;
         pf_cnt_q     <= pf_cnt_d;
         simd_cnt_q   <= simd_cnt_d;
         pf_valid_q   <= pf_valid_d;
         simd_valid_q <= simd_valid_d;
         pf_data_q    <= pf_data_d;
         simd_data_q  <= simd_data_d;
         err_q        <= err_d;
      end
   end

   assign q_pop      = pop_ok;
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);
   assign err        = err_q;
   assign pf_valid   = pf_valid_q;
   assign pf_data    = pf_data_q;
   assign simd_valid = simd_valid_q;
   assign simd_data  = simd_data_q;

endmodule

// File: tb/tb_wi_dispatch.sv
// Self-checking bench for wi_dispatch: queue/core environment plus a transaction-level model of
// workload progress, outstanding items and output registers, compared every cycle.
module tb_wi_dispatch;
   localparam int unsigned WI   = 64;
   localparam int unsigned WL   = 32;
   localparam int          MAXO = 4;

   logic          clk = 1'b0;
   logic          rst_n, start;
   logic [WL-1:0] wl_len;
   logic          busy, done, err, q_empty, q_pop;
   logic [WI-1:0] q_data, pf_data, simd_data;
   logic          pf_valid, simd_valid, pf_ready, simd_ready, pf_cmpl, simd_cmpl;

   wi_dispatch #(.WI_WIDTH(WI), .WL_LEN_BITS(WL), .MAX_OUT(MAXO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .wl_len(wl_len), .busy(busy), .done(done),
      .err(err), .q_empty(q_empty), .q_pop(q_pop), .q_data(q_data),
      .pf_valid(pf_valid), .pf_data(pf_data), .pf_ready(pf_ready), .pf_cmpl(pf_cmpl),
      .simd_valid(simd_valid), .simd_data(simd_data), .simd_ready(simd_ready),
      .simd_cmpl(simd_cmpl)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0, cyc = 0;
   // Model: 0 idle, 1 issuing, 2 waiting for completions, 3 done pulse
   logic [WI-1:0] wq[$];
   int            m_len, m_iss, m_cmp, m_ph;
   bit            m_err;
   int            m_oc[2];
   bit            m_v[2];
   logic [WI-1:0] m_d[2];
   int            sch0[$], sch1[$];
   // Environment knobs: rdy_mode 0 always ready, 1 random, 2 never ready
   int            rdy_mode[2];
   bit            auto_cmpl;
   int            cdelay;
   bit            man_cmpl[2];
   bit            r[2], cm[2], e_pop;
   int            tgt;
   logic [5:0]    e_ctl;
   int            npop, ndone;

   function automatic logic [WI-1:0] item(bit simd);
      return {simd, 31'($urandom), 32'($urandom)};
   endfunction

   task automatic model_clear();
      m_len = 0; m_iss = 0; m_cmp = 0; m_ph = 0; m_err = 0;
      for (int c = 0; c < 2; c++) begin
         m_oc[c] = 0; m_v[c] = 0; m_d[c] = '0;
      end
      sch0.delete(); sch1.delete();
   endtask

   task automatic drive();
      bit due0, due1;
      q_empty = (wq.size() == 0);
      q_data  = q_empty ? {$urandom, $urandom} : wq[0];
      for (int c = 0; c < 2; c++)
         r[c] = (rdy_mode[c] == 0) ? 1'b1 : (rdy_mode[c] == 1) ? 1'($urandom) : 1'b0;
      due0  = sch0.size() > 0 && sch0[0] <= cyc;
      due1  = sch1.size() > 0 && sch1[0] <= cyc;
      cm[0] = man_cmpl[0] || (auto_cmpl && due0);
      cm[1] = man_cmpl[1] || (auto_cmpl && due1);
      pf_ready = r[0]; simd_ready = r[1]; pf_cmpl = cm[0]; simd_cmpl = cm[1];
      tgt   = q_empty ? 0 : int'(wq[0][WI-1]);
      e_pop = m_ph == 1 && !q_empty && m_iss < m_len && m_oc[tgt] < MAXO &&
              (!m_v[tgt] || r[tgt]);
      e_ctl = {e_pop, m_ph != 0, m_ph == 3, m_err, m_v[0], m_v[1]};
   endtask

   task automatic advance();
      int old_iss = m_iss;
      int old_cmp = m_cmp;
      int t;
      bit ok;
      for (int c = 0; c < 2; c++) begin
         if (cm[c]) begin
            if (c == 0 && sch0.size() > 0) void'(sch0.pop_front());
            if (c == 1 && sch1.size() > 0) void'(sch1.pop_front());
         end
         if (m_v[c] && r[c]) begin
            t = cyc + ((cdelay > 0) ? cdelay : int'($urandom_range(6, 1)));
            if (c == 0) sch0.push_back(t);
            else sch1.push_back(t);
         end
         ok = cm[c] && m_oc[c] > 0;
         if (cm[c] && m_oc[c] == 0) m_err = 1;
         if (ok) begin
            m_cmp++;
            m_oc[c]--;
         end
         if (e_pop && tgt == c) begin
            m_oc[c]++;
            m_v[c] = 1;
            m_d[c] = wq[0];
         end else if (m_v[c] && r[c]) begin
            m_v[c] = 0;
         end
      end
      if (e_pop) begin
         void'(wq.pop_front());
         m_iss++;
      end
      case (m_ph)
         0: if (start) begin
            m_len = int'(wl_len); m_iss = 0; m_cmp = 0;
            m_ph  = (wl_len != 0) ? 1 : 3;
         end
         1: if (old_iss == m_len) m_ph = 2;
         2: if (old_cmp == m_len) m_ph = 3;
         default: m_ph = 0;
      endcase
      @(posedge clk);
      #1;
      cyc++;
      start = 0; man_cmpl[0] = 0; man_cmpl[1] = 0;
   endtask

   task automatic apply_reset();
      rst_n = 0; start = 0; man_cmpl[0] = 0; man_cmpl[1] = 0; auto_cmpl = 0;
      drive();
      @(posedge clk);
      #1;
      cyc++;
      rst_n = 1;
      model_clear();
   endtask

   task automatic begin_wl(int len);
      npop = 0; ndone = 0;
      wl_len = WL'(len);
      start = 1;
   endtask

   task automatic test_reset();
      apply_reset();
      wq.delete();
      wq.push_back(item(0));
      npop = 0; ndone = 0;
      for (int i = 0; i < 3; i++) begin
         drive(); #2;
         total++;
         if ({q_pop, busy, done, err, pf_valid, simd_valid, pf_data, simd_data} !==
             {e_ctl, m_d[0], m_d[1]}) begin
            bad++;
            $display("FAIL reset_cycle cyc=%0d got=%b exp=%b", cyc,
                     {q_pop, busy, done, err, pf_valid, simd_valid}, e_ctl);
         end
         if (i == 0) begin
            total++;
            if ({q_pop, busy, done, err, pf_valid, simd_valid, pf_data, simd_data} !== '0) begin
               bad++;
               $display("FAIL reset_values got=%b pf=%h simd=%h exp=all zero",
                        {q_pop, busy, done, err, pf_valid, simd_valid}, pf_data, simd_data);
            end
         end
         advance();
      end
   endtask

   task automatic test_basic();
      int fp = -1, lp = -1;
      wq.delete();
      wq.push_back(item(0)); wq.push_back(item(1)); wq.push_back(item(0));
      rdy_mode[0] = 0; rdy_mode[1] = 0; auto_cmpl = 1; cdelay = 2;
      begin_wl(3);
      for (int i = 0; i < 60; i++) begin
         drive(); #2;
         total++;
         if ({q_pop, busy, done, err, pf_valid, simd_valid, pf_data, simd_data} !==
             {e_ctl, m_d[0], m_d[1]}) begin
            bad++;
            $display("FAIL basic_cycle cyc=%0d got=%b exp=%b", cyc,
                     {q_pop, busy, done, err, pf_valid, simd_valid}, e_ctl);
         end
         if (q_pop) begin
            if (fp < 0) fp = cyc;
            lp = cyc;
         end
         npop += int'(q_pop); ndone += int'(done);
         advance();
         if (ndone > 0 && m_ph == 0) break;
      end
      total++;
      if (npop != 3 || lp - fp != 2 || ndone != 1 || err !== 1'b0) begin
         bad++;
         $display("FAIL basic_summary pops=%0d span=%0d dones=%0d err=%b exp 3/2/1/0",
                  npop, lp - fp, ndone, err);
      end
   endtask

   task automatic test_max_out();
      wq.delete();
      for (int k = 0; k < 6; k++) wq.push_back(item(0));
      rdy_mode[0] = 0; rdy_mode[1] = 0; auto_cmpl = 0; cdelay = 2;
      begin_wl(6);
      for (int i = 0; i < 12; i++) begin
         drive(); #2;
         total++;
         if ({q_pop, busy, done, err, pf_valid, simd_valid, pf_data, simd_data} !==
             {e_ctl, m_d[0], m_d[1]}) begin
            bad++;
            $display("FAIL maxout_cycle cyc=%0d got=%b exp=%b", cyc,
                     {q_pop, busy, done, err, pf_valid, simd_valid}, e_ctl);
         end
         npop += int'(q_pop);
         advance();
      end
      total++;
      if (npop != MAXO || q_pop !== 1'b0) begin
         bad++;
         $display("FAIL maxout_limit pops=%0d q_pop=%b exp %0d/0", npop, q_pop, MAXO);
      end
      man_cmpl[0] = 1;
      for (int i = 0; i < 2; i++) begin
         drive(); #2;
         if (i == 1) begin
            total++;
            if (q_pop !== 1'b1) begin
               bad++;
               $display("FAIL maxout_refill q_pop=%b exp=1", q_pop);
            end
         end
         advance();
      end
      auto_cmpl = 1;
      for (int i = 0; i < 80; i++) begin
         drive(); #2;
         total++;
         if ({q_pop, busy, done, err, pf_valid, simd_valid, pf_data, simd_data} !==
             {e_ctl, m_d[0], m_d[1]}) begin
            bad++;
            $display("FAIL maxout_finish cyc=%0d got=%b exp=%b", cyc,
                     {q_pop, busy, done, err, pf_valid, simd_valid}, e_ctl);
         end
         ndone += int'(done);
         advance();
         if (ndone > 0 && m_ph == 0) break;
      end
      total++;
      if (ndone != 1 || err !== 1'b0) begin
         bad++;
         $display("FAIL maxout_done dones=%0d err=%b exp 1/0", ndone, err);
      end
   endtask

   task automatic test_stall();
      logic [WI-1:0] held = '0;
      bit have = 0, stable = 1, simd_seen = 0;
      wq.delete();
      wq.push_back(item(0)); wq.push_back(item(0)); wq.push_back(item(1));
      rdy_mode[0] = 2; rdy_mode[1] = 0; auto_cmpl = 1; cdelay = 0;
      begin_wl(3);
      for (int i = 0; i < 9; i++) begin
         if (i == 4) begin
            start = 1; wl_len = '0;
         end
         drive(); #2;
         total++;
         if ({q_pop, busy, done, err, pf_valid, simd_valid, pf_data, simd_data} !==
             {e_ctl, m_d[0], m_d[1]}) begin
            bad++;
            $display("FAIL stall_cycle cyc=%0d got=%b exp=%b", cyc,
                     {q_pop, busy, done, err, pf_valid, simd_valid}, e_ctl);
         end
         if (pf_valid && !have) begin
            held = pf_data; have = 1;
         end else if (have && pf_data !== held) begin
            stable = 0;
         end
         if (simd_valid) simd_seen = 1;
         npop += int'(q_pop);
         advance();
      end
      total++;
      if (!have || !stable || simd_seen || npop != 1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL stall_hold valid=%b stable=%b simd=%b pops=%0d busy=%b exp 1/1/0/1/1",
                  have, stable, simd_seen, npop, busy);
      end
      rdy_mode[0] = 0;
      for (int i = 0; i < 80; i++) begin
         drive(); #2;
         total++;
         if ({q_pop, busy, done, err, pf_valid, simd_valid, pf_data, simd_data} !==
             {e_ctl, m_d[0], m_d[1]}) begin
            bad++;
            $display("FAIL stall_release cyc=%0d got=%b exp=%b", cyc,
                     {q_pop, busy, done, err, pf_valid, simd_valid}, e_ctl);
         end
         ndone += int'(done);
         advance();
         if (ndone > 0 && m_ph == 0) break;
      end
      total++;
      if (ndone != 1 || err !== 1'b0) begin
         bad++;
         $display("FAIL stall_done dones=%0d err=%b exp 1/0", ndone, err);
      end
   endtask

   task automatic test_zero_len();
      wq.delete();
      wq.push_back(item(0)); wq.push_back(item(1));
      rdy_mode[0] = 0; rdy_mode[1] = 0; auto_cmpl = 1; cdelay = 0;
      begin_wl(0);
      for (int i = 0; i < 4; i++) begin
         drive(); #2;
         total++;
         if ({q_pop, busy, done, err, pf_valid, simd_valid, pf_data, simd_data} !==
             {e_ctl, m_d[0], m_d[1]}) begin
            bad++;
            $display("FAIL zero_cycle cyc=%0d got=%b exp=%b", cyc,
                     {q_pop, busy, done, err, pf_valid, simd_valid}, e_ctl);
         end
         if (i == 1) begin
            total++;
            if (done !== 1'b1) begin
               bad++;
               $display("FAIL zero_done_timing done=%b exp=1", done);
            end
         end
         npop += int'(q_pop); ndone += int'(done);
         advance();
      end
      total++;
      if (npop != 0 || ndone != 1) begin
         bad++;
         $display("FAIL zero_summary pops=%0d dones=%0d exp 0/1", npop, ndone);
      end
   endtask

   task automatic test_dual_cmpl();
      int dk = -1;
      wq.delete();
      wq.push_back(item(0)); wq.push_back(item(1));
      rdy_mode[0] = 0; rdy_mode[1] = 0; auto_cmpl = 0; cdelay = 1;
      begin_wl(2);
      for (int i = 0; i < 6; i++) begin
         drive(); #2;
         total++;
         if ({q_pop, busy, done, err, pf_valid, simd_valid, pf_data, simd_data} !==
             {e_ctl, m_d[0], m_d[1]}) begin
            bad++;
            $display("FAIL dual_issue cyc=%0d got=%b exp=%b", cyc,
                     {q_pop, busy, done, err, pf_valid, simd_valid}, e_ctl);
         end
         advance();
      end
      man_cmpl[0] = 1; man_cmpl[1] = 1;
      for (int k = 0; k < 6; k++) begin
         drive(); #2;
         total++;
         if ({q_pop, busy, done, err, pf_valid, simd_valid, pf_data, simd_data} !==
             {e_ctl, m_d[0], m_d[1]}) begin
            bad++;
            $display("FAIL dual_cmpl cyc=%0d got=%b exp=%b", cyc,
                     {q_pop, busy, done, err, pf_valid, simd_valid}, e_ctl);
         end
         if (done && dk < 0) dk = k;
         advance();
      end
      total++;
      if (dk != 2 || err !== 1'b0) begin
         bad++;
         $display("FAIL dual_done_latency got=%0d err=%b exp 2/0", dk, err);
      end
      man_cmpl[1] = 1;
      for (int i = 0; i < 5; i++) begin
         drive(); #2;
         total++;
         if ({q_pop, busy, done, err, pf_valid, simd_valid, pf_data, simd_data} !==
             {e_ctl, m_d[0], m_d[1]}) begin
            bad++;
            $display("FAIL dual_spurious cyc=%0d got=%b exp=%b", cyc,
                     {q_pop, busy, done, err, pf_valid, simd_valid}, e_ctl);
         end
         advance();
      end
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL dual_err_sticky err=%b exp=1", err);
      end
   endtask

   task automatic test_reset_drain();
      wq.delete();
      wq.push_back(item(0)); wq.push_back(item(0));
      rdy_mode[0] = 0; rdy_mode[1] = 0; auto_cmpl = 0; cdelay = 1;
      begin_wl(2);
      for (int i = 0; i < 6; i++) begin
         drive(); #2;
         total++;
         if ({q_pop, busy, done, err, pf_valid, simd_valid, pf_data, simd_data} !==
             {e_ctl, m_d[0], m_d[1]}) begin
            bad++;
            $display("FAIL rstdrain_issue cyc=%0d got=%b exp=%b", cyc,
                     {q_pop, busy, done, err, pf_valid, simd_valid}, e_ctl);
         end
         advance();
      end
      total++;
      if (busy !== 1'b1 || m_ph != 2) begin
         bad++;
         $display("FAIL rstdrain_in_drain busy=%b phase=%0d exp 1/2", busy, m_ph);
      end
      apply_reset();
      wq.delete();
      for (int k = 0; k < 3; k++) wq.push_back(item(1'($urandom)));
      drive(); #2;
      total++;
      if ({q_pop, busy, done, err, pf_valid, simd_valid, pf_data, simd_data} !== '0) begin
         bad++;
         $display("FAIL rstdrain_values got=%b pf=%h simd=%h exp=all zero",
                  {q_pop, busy, done, err, pf_valid, simd_valid}, pf_data, simd_data);
      end
      advance();
      rdy_mode[0] = 1; rdy_mode[1] = 1; auto_cmpl = 1; cdelay = 0;
      begin_wl(3);
      for (int i = 0; i < 120; i++) begin
         drive(); #2;
         total++;
         if ({q_pop, busy, done, err, pf_valid, simd_valid, pf_data, simd_data} !==
             {e_ctl, m_d[0], m_d[1]}) begin
            bad++;
            $display("FAIL rstdrain_restart cyc=%0d got=%b exp=%b", cyc,
                     {q_pop, busy, done, err, pf_valid, simd_valid}, e_ctl);
         end
         npop += int'(q_pop); ndone += int'(done);
         advance();
         if (ndone > 0 && m_ph == 0) break;
      end
      total++;
      if (ndone != 1 || npop != 3 || err !== 1'b0) begin
         bad++;
         $display("FAIL rstdrain_summary dones=%0d pops=%0d err=%b exp 1/3/0", ndone, npop, err);
      end
   endtask

   task automatic test_random();
      int len;
      for (int w = 0; w < 6; w++) begin
         wq.delete();
         len = int'($urandom_range(12, 1));
         for (int k = 0; k < len + int'($urandom_range(3, 0)); k++)
            wq.push_back(item(1'($urandom)));
         rdy_mode[0] = int'($urandom_range(1, 0));
         rdy_mode[1] = int'($urandom_range(1, 0));
         auto_cmpl = 1; cdelay = 0;
         begin_wl(len);
         for (int i = 0; i < 400; i++) begin
            drive(); #2;
            total++;
            if ({q_pop, busy, done, err, pf_valid, simd_valid, pf_data, simd_data} !==
                {e_ctl, m_d[0], m_d[1]}) begin
               bad++;
               $display("FAIL random_cycle wl=%0d cyc=%0d got=%b exp=%b", w, cyc,
                        {q_pop, busy, done, err, pf_valid, simd_valid}, e_ctl);
            end
            npop += int'(q_pop); ndone += int'(done);
            advance();
            if (ndone > 0 && m_ph == 0) break;
         end
         total++;
         if (ndone != 1 || npop != len || err !== 1'b0) begin
            bad++;
            $display("FAIL random_summary wl=%0d dones=%0d pops=%0d err=%b exp 1/%0d/0",
                     w, ndone, npop, err, len);
         end
      end
   endtask

   initial begin
      rst_n = 0; start = 0; wl_len = '0;
      rdy_mode[0] = 0; rdy_mode[1] = 0; auto_cmpl = 0; cdelay = 0;
      man_cmpl[0] = 0; man_cmpl[1] = 0;
      model_clear();
      test_reset();
      test_basic();
      test_max_out();
      test_stall();
      test_zero_len();
      test_dual_cmpl();
      test_reset_drain();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
